sw_result_collector: RTL

Downstream consumer of the SmithWaterman core's per-target score stream. Accumulates each query's best and second-best target scores, threshold-hit count and target count, then forms one summary record when the query completes. Records queue in a small FIFO drained by the host through a valid/ready handshake. The core cannot stall, so records arriving at a full FIFO are dropped and flagged.

---
 rtl/sw_pkg.sv | 33 +++
 rtl/sw_rec_fifo.sv | 43 ++++
 rtl/sw_result_collector.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared widths, record and rank-entry types for the SmithWaterman result collector.
// Width constants follow the core's CALC_BIT / MAX_T_NUM_BIT macros when those are defined.
`ifndef CALC_BIT
`define CALC_BIT 16
`endif
`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 8
`endif
package sw_pkg;
   localparam int SW_SCORE_W = `CALC_BIT;
   localparam int SW_TIDX_W  = `MAX_T_NUM_BIT;
   localparam int SW_QIDX_W  = 8;

   typedef struct packed {
      logic [SW_QIDX_W-1:0]  qidx;
      logic [SW_TIDX_W-1:0]  best_tidx;
      logic [SW_SCORE_W-1:0] best_score;
      logic [SW_TIDX_W-1:0]  second_tidx;
      logic [SW_SCORE_W-1:0] second_score;
      logic [SW_TIDX_W-1:0]  hits;
      logic [SW_TIDX_W-1:0]  ntargets;
   } sw_rec_t;

   typedef struct packed {
      logic [SW_SCORE_W-1:0] score;
      logic [SW_TIDX_W-1:0]  tidx;
      logic                  vld;
   } sw_rank_t;

   function automatic logic [SW_TIDX_W-1:0] sat_inc(input logic [SW_TIDX_W-1:0] v);
      return &v ? v : v + SW_TIDX_W'(1);
   endfunction
endpackage

// File: rtl/sw_rec_fifo.sv
// sw_rec_fifo: synchronous record FIFO; the caller decides when a push is legal.
module sw_rec_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_data,
   output logic [W-1:0]  o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_cnt;

   assign o_full  = r_cnt == CW'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   // Empty reads as zero so the record outputs idle at 0.
   assign o_data  = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr] <= i_data;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(1);
         if (i_pop) r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end
endmodule

// File: rtl/sw_result_collector.sv
// sw_result_collector: ranks per-target scores of each query and queues one summary record per query.
// Define SW_COLLECT_SECOND_EN to track the second-best target; otherwise its fields read 0.
module sw_result_collector
   import sw_pkg::*;
#(
   parameter int SCORE_W    = SW_SCORE_W,
   parameter int TIDX_W     = SW_TIDX_W,
   parameter int QIDX_W     = SW_QIDX_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear_i,
   input  logic                         valid_i,
   input  logic [SCORE_W-1:0]           result_i,
   input  logic                         change_q_i,
   input  logic [SCORE_W-1:0]           thresh_i,
   output logic                         rec_valid_o,
   input  logic                         rec_ready_i,
   output logic [QIDX_W-1:0]            rec_qidx_o,
   output logic [TIDX_W-1:0]            rec_best_tidx_o,
   output logic [SCORE_W-1:0]           rec_best_score_o,
   output logic [TIDX_W-1:0]            rec_second_tidx_o,
   output logic [SCORE_W-1:0]           rec_second_score_o,
   output logic [TIDX_W-1:0]            rec_hits_o,
   output logic [TIDX_W-1:0]            rec_ntargets_o,
   output logic                         overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
   typedef enum logic {S_IDLE, S_ACCUM} state_t;

`ifdef SW_COLLECT_SECOND_EN
   localparam int REC_W = $bits(sw_rec_t);
`else
   localparam int REC_W = $bits(sw_rec_t) - SW_TIDX_W - SW_SCORE_W;
`endif

   state_t             r_state, w_state_n;
   logic [TIDX_W-1:0]  r_tcnt, r_hits, w_tcnt_n, w_hits_n;
   logic [QIDX_W-1:0]  r_qcnt;
   logic               r_ovf;
   sw_rank_t           r_best, w_best_n, w_new;
   logic               w_beat_best, w_last, w_push, w_pop, w_full, w_empty;
   logic [REC_W-1:0]   w_fifo_in, w_fifo_out;
   sw_rec_t            w_rec_out;

   always_comb begin
      w_state_n = r_state;
      if (clear_i) w_state_n = S_IDLE;
      else if (valid_i) w_state_n = change_q_i ? S_IDLE : S_ACCUM;
   end

   always_ff @(posedge clk)
      r_state <= rst ? S_IDLE : w_state_n;

   // Strict compare: an equal later score never displaces an earlier one.
   assign w_new       = '{score: result_i, tidx: r_tcnt, vld: 1'b1};
   assign w_beat_best = !r_best.vld || result_i > r_best.score;
   assign w_best_n    = w_beat_best ? w_new : r_best;
   assign w_hits_n    = result_i >= thresh_i ? sat_inc(r_hits) : r_hits;
   assign w_tcnt_n    = sat_inc(r_tcnt);
   assign w_last      = valid_i && change_q_i && !clear_i;
   assign w_pop       = rec_valid_o && rec_ready_i;
   assign w_push      = w_last && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         r_tcnt <= '0;
         r_hits <= '0;
         r_best <= '0;
         r_qcnt <= '0;
         r_ovf  <= 1'b0;
      end else if (w_last) begin
         r_tcnt <= '0;
         r_hits <= '0;
         r_best <= '0;
         r_qcnt <= r_qcnt + QIDX_W'(1);
         r_ovf  <= r_ovf | !w_push;
      end else if (valid_i) begin
         r_tcnt <= w_tcnt_n;
         r_hits <= w_hits_n;
         r_best <= w_best_n;
      end
   end

`ifdef SW_COLLECT_SECOND_EN
   sw_rank_t r_second, w_second_n;

   assign w_second_n = w_beat_best ? r_best :
                       (!r_second.vld || result_i > r_second.score) ? w_new : r_second;

   always_ff @(posedge clk) begin
      if (rst || clear_i || w_last) r_second <= '0;
      else if (valid_i) r_second <= w_second_n;
   end

   assign w_fifo_in = {r_qcnt, w_best_n.tidx, w_best_n.score, w_second_n.tidx, w_second_n.score,
                       w_hits_n, w_tcnt_n};
   assign w_rec_out = w_fifo_out;
`else
   assign w_fifo_in = {r_qcnt, w_best_n.tidx, w_best_n.score, w_hits_n, w_tcnt_n};
   assign w_rec_out = {w_fifo_out[REC_W-1:2*SW_TIDX_W], {(SW_TIDX_W+SW_SCORE_W){1'b0}},
                       w_fifo_out[2*SW_TIDX_W-1:0]};
`endif

   sw_rec_fifo #(.DEPTH(FIFO_DEPTH), .W(REC_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (clear_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_fifo_in),
      .o_data  (w_fifo_out),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count_o)
   );

   assign rec_valid_o        = !w_empty;
   assign overflow_o         = r_ovf;
   assign rec_qidx_o         = w_rec_out.qidx;
   assign rec_best_tidx_o    = w_rec_out.best_tidx;
   assign rec_best_score_o   = w_rec_out.best_score;
   assign rec_second_tidx_o  = w_rec_out.second_tidx;
   assign rec_second_score_o = w_rec_out.second_score;
   assign rec_hits_o         = w_rec_out.hits;
   assign rec_ntargets_o     = w_rec_out.ntargets;
endmodule
